// File: rtl/reset_sequencer.sv
// Lock-qualified clock enable and staggered multi-channel reset release with button restart.
// Optional button debounce is built when RESET_SEQUENCER_DEBOUNCE_EN is defined.
module reset_sequencer #(
  parameter int N_CH            = 3,
  parameter int LOCK_CYCLES     = 8,
  parameter int STEP_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            locked,
  input  logic            btn,
  output logic            clk_en,
  output logic [N_CH-1:0] rst_out,
  output logic            ready,
  output logic            lock_err
);

  localparam int MAX_CYCLES = (LOCK_CYCLES > STEP_CYCLES) ? LOCK_CYCLES : STEP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int CHW        = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CW-1:0]  LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0]  STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CHW-1:0] LAST_CH   = CHW'(N_CH - 1);

  localparam logic [2:0] WAIT_LOCK = 3'd0;
  localparam logic [2:0] STABILIZE = 3'd1;
  localparam logic [2:0] CLK_ON    = 3'd2;
  localparam logic [2:0] RELEASE   = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;
  localparam logic [2:0] HOLD      = 3'd5;

  logic locked_meta_reg, locked_s_reg;
  logic btn_meta_reg, btn_s_reg;
  logic btn_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_meta_reg <= 1'b0;
      locked_s_reg    <= 1'b0;
      btn_meta_reg    <= 1'b0;
      btn_s_reg       <= 1'b0;
    end else begin
      locked_meta_reg <= locked;
      locked_s_reg    <= locked_meta_reg;
      btn_meta_reg    <= btn;
      btn_s_reg       <= btn_meta_reg;
    end
  end

`ifdef RESET_SEQUENCER_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt_reg;
  logic          btn_req_reg;

  // The request flips only after a full run of samples at the opposite level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_reg  <= '0;
      btn_req_reg <= 1'b0;
    end else if (btn_s_reg != btn_req_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        db_cnt_reg  <= '0;
        btn_req_reg <= btn_s_reg;
      end else begin
        db_cnt_reg <= db_cnt_reg + DW'(1);
      end
    end else begin
      db_cnt_reg <= '0;
    end
  end

  assign btn_req = btn_req_reg;
`else
  assign btn_req = btn_s_reg;
`endif

  logic [2:0]     state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [CHW-1:0] ch_idx_reg, ch_idx_next;
  logic           clk_en_reg, clk_en_next;
  logic           ready_reg, ready_next;
  logic           lock_err_reg, lock_err_next;
  logic           set_all;
  logic           clr_en;
  logic [CHW-1:0] clr_idx;
  logic           lock_lost;

  assign lock_lost = !locked_s_reg &&
                     (state_reg == CLK_ON || state_reg == RELEASE ||
                      state_reg == RUN    || state_reg == HOLD);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    ch_idx_next   = ch_idx_reg;
    clk_en_next   = clk_en_reg;
    ready_next    = ready_reg;
    lock_err_next = lock_err_reg;
    set_all       = 1'b0;
    clr_en        = 1'b0;
    clr_idx       = ch_idx_reg;

    case (state_reg)
      WAIT_LOCK: begin
        clk_en_next = 1'b0;
        ready_next  = 1'b0;
        set_all     = 1'b1;
        if (locked_s_reg) begin
          state_next = STABILIZE;
          cnt_next   = '0;
        end
      end
      STABILIZE: begin
        if (!locked_s_reg) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == LOCK_LAST) begin
          state_next  = CLK_ON;
          cnt_next    = '0;
          clk_en_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      CLK_ON: begin
        if (cnt_reg == STEP_LAST) begin
          clr_en   = 1'b1;
          clr_idx  = '0;
          cnt_next = '0;
          if (N_CH == 1) begin
            state_next = RUN;
            ready_next = 1'b1;
          end else begin
            state_next  = RELEASE;
            ch_idx_next = CHW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RELEASE: begin
        if (cnt_reg == STEP_LAST) begin
          clr_en   = 1'b1;
          clr_idx  = ch_idx_reg;
          cnt_next = '0;
          if (ch_idx_reg == LAST_CH) begin
            state_next = RUN;
            ready_next = 1'b1;
          end else begin
            ch_idx_next = ch_idx_reg + CHW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RUN: begin
        if (btn_req) begin
          state_next = HOLD;
          cnt_next   = '0;
          ready_next = 1'b0;
          set_all    = 1'b1;
        end
      end
      HOLD: begin
        if (!btn_req) begin
          state_next = CLK_ON;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase

    // Losing lock once the clock is enabled overrides everything, including a button request.
    if (lock_lost) begin
      state_next    = WAIT_LOCK;
      cnt_next      = '0;
      ch_idx_next   = '0;
      clk_en_next   = 1'b0;
      ready_next    = 1'b0;
      lock_err_next = 1'b1;
      set_all       = 1'b1;
      clr_en        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= WAIT_LOCK;
      cnt_reg      <= '0;
      ch_idx_reg   <= '0;
      clk_en_reg   <= 1'b0;
      ready_reg    <= 1'b0;
      lock_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ch_idx_reg   <= ch_idx_next;
      clk_en_reg   <= clk_en_next;
      ready_reg    <= ready_next;
      lock_err_reg <= lock_err_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic rst_bit_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rst_bit_reg <= 1'b1;
        end else if (set_all) begin
          rst_bit_reg <= 1'b1;
        end else if (clr_en && (clr_idx == CHW'(gi))) begin
          rst_bit_reg <= 1'b0;
        end
      end

      assign rst_out[gi] = rst_bit_reg;
    end
  endgenerate

  assign clk_en   = clk_en_reg;
  assign ready    = ready_reg;
  assign lock_err = lock_err_reg;

endmodule
